buzzer_pattern_gen: RTL and testbench
=====================================

# buzzer_pattern_gen

Event-driven buzzer sequencer placed downstream of the keypad decode and guess-game logic, alongside the digit display. It converts single-cycle game events (valid key press, correct guess, out of tries) into timed square-wave tone patterns on the buzzer pin, so the game logic no longer drives the buzzer directly. A higher-priority event pre-empts a pattern that is already playing.

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz
- UNIT_MS, 100, length of one pattern time unit in ms
- TONE_HI_HZ, 2000, high tone frequency (key beep, success)
- TONE_LO_HZ, 1000, low tone frequency (failure)

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  system clock
- RST  input  1  asynchronous active-high reset
- evt_key  input  1  one-cycle pulse: valid key press accepted
- evt_ok  input  1  one-cycle pulse: correct guess
- evt_fail  input  1  one-cycle pulse: tries exhausted
- buzzer  output  1  square-wave drive to passive buzzer, registered
- busy  output  1  high while a pattern is playing, registered

## Operation
- Derived constants: UNIT_CYC = CLK_HZ/1000*UNIT_MS; HALF_HI = CLK_HZ/(2*TONE_HI_HZ); HALF_LO = CLK_HZ/(2*TONE_LO_HZ). All are integer divisions. Each must be ≥1; violating parameters are rejected at elaboration.
- Patterns, in units:
  - KEY: one HI tone of 1 unit.
  - OK: HI tone 1, gap 1, HI tone 1, gap 1, HI tone 1 (5 units).
  - FAIL: one LO tone of 5 units.
- Priority is FAIL > OK > KEY > none. If several events arrive in the same cycle, only the highest is taken.
- FSM states:
  - IDLE: accepts any event and moves to TONE.
  - TONE: counts the tone length. At the end, moves to GAP if beeps remain, otherwise to IDLE.
  - GAP: counts 1 unit, then moves to TONE.
- Pre-emption: an event with strictly higher priority than the pattern now playing restarts the FSM in TONE with the new pattern. An event of equal or lower priority is ignored. A KEY during KEY is ignored and does not retrigger.
- Tone generation: the phase counter and buzzer level restart at every TONE entry. buzzer toggles every HALF_x cycles, and its first half-period is high. In IDLE and GAP, buzzer is 0.
- Counter widths: $clog2(UNIT_CYC*5+1) for the unit/duration counter; $clog2(HALF_LO+1) for the phase counter. No counter wraps: each one is reloaded at a state transition.

## Timing
- Reset (asynchronous): state IDLE, buzzer 0, busy 0, all counters 0. Asserting RST mid-pattern silences buzzer immediately.
- Event sampled at rising edge n. busy and buzzer are 1 from cycle n+1.
- Each TONE or GAP segment lasts exactly len*UNIT_CYC cycles.
- busy falls in the cycle after the last tone cycle, together with buzzer=0.
- Busy durations: KEY 1*UNIT_CYC, OK 5*UNIT_CYC, FAIL 5*UNIT_CYC.
- Pre-emption takes effect at n+1. The new pattern's full duration counts from n+1.
- An event in the same cycle that a pattern ends is accepted. There is no dead cycle: busy stays high.

## Structure
- Package buzzer_pkg holds:
  - the state enum (IDLE/TONE/GAP);
  - the pattern id enum (NONE/KEY/OK/FAIL), ordered by priority;
  - per-pattern constants: beep count, tone units, gap units, tone select.
- One sub-module, tone_divider, is natural: it takes enable, restart and half-period inputs and produces a square wave output. The sequencer FSM stays in buzzer_pattern_gen.

## Test plan
All scenarios use CLK_HZ=20000, UNIT_MS=1, TONE_HI_HZ=2000, TONE_LO_HZ=1000, which gives UNIT_CYC=20, HALF_HI=5, HALF_LO=10.
- Reset and idle: RST high, then released, with no events. Required: buzzer=0 and busy=0 for 200 cycles. Asserting RST mid-FAIL forces buzzer=0 and busy=0 in the same cycle.
- KEY pulse at cycle 10. Required: buzzer is 1 on cycles 11–15, 0 on 16–20, 1 on 21–25, 0 on 26–30. busy is 1 on cycles 11–30 and 0 at cycle 31.
- OK pulse. Required: three bursts of 20 cycles (2 HI periods each), separated by 20-cycle silent gaps. busy is high for exactly 100 cycles.
- FAIL pulse. Required: 5 full LO periods (10 high, 10 low). busy is high for exactly 100 cycles.
- Priority and pre-emption:
  - evt_key and evt_fail in the same cycle: FAIL pattern only.
  - evt_ok at cycle 5 of a KEY pattern: OK restarts at the next cycle, and busy lasts 100 cycles from there.
  - evt_key during OK: ignored, and total duration is unchanged.
- Back-to-back: a KEY pulse in the final busy cycle of a KEY pattern gives busy continuously high for 40 cycles, and the second burst starts high.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared types and per-pattern constants for the buzzer sequencer.
package buzzer_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TONE = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Pattern ids, numerically ordered by priority (higher value wins)
   typedef enum logic [1:0] {
      PAT_NONE = 2'd0,
      PAT_KEY  = 2'd1,
      PAT_OK   = 2'd2,
      PAT_FAIL = 2'd3
   } pat_t;

   localparam int UNITS_W = 3;

   // Number of tone beeps in a pattern
   function automatic logic [UNITS_W-1:0] pat_beeps(input pat_t p);
      case (p)
         PAT_KEY:  return 3'd1;
         PAT_OK:   return 3'd3;
         PAT_FAIL: return 3'd1;
         default:  return 3'd0;
      endcase
   endfunction

   // Length of each tone in units
   function automatic logic [UNITS_W-1:0] pat_tone_units(input pat_t p);
      case (p)
         PAT_KEY:  return 3'd1;
         PAT_OK:   return 3'd1;
         PAT_FAIL: return 3'd5;
         default:  return 3'd0;
      endcase
   endfunction

   // Length of the silent gap between beeps in units
   function automatic logic [UNITS_W-1:0] pat_gap_units(input pat_t p);
      case (p)
         PAT_OK:  return 3'd1;
         default: return 3'd0;
      endcase
   endfunction

   // Tone select: 1 = low tone, 0 = high tone
   function automatic logic pat_tone_lo(input pat_t p);
      case (p)
         PAT_FAIL: return 1'b1;
         default:  return 1'b0;
      endcase
   endfunction

   // Priority encoder for simultaneous event pulses
   function automatic pat_t pat_of_events(input logic fail, input logic ok, input logic key);
      pat_t p;
      if (fail) begin
         p = PAT_FAIL;
      end else if (ok) begin
         p = PAT_OK;
      end else if (key) begin
         p = PAT_KEY;
      end else begin
         p = PAT_NONE;
      end
      return p;
   endfunction

endpackage

// File: rtl/buzzer_pattern_gen_tone_divider.sv
// Square-wave generator: restart forces the first (high) half-period,
// enable keeps toggling every 'half' cycles, otherwise the output is silent.
module tone_divider #(
   parameter int PH_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic            restart,
   input  logic [PH_W-1:0] half,
   output logic            wave
);

   logic [PH_W-1:0] phase_r;
   logic            wave_r;

   // Phase counter and output level; restart wins over enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_r <= {PH_W{1'b0}};
         wave_r  <= 1'b0;
      end else if (restart) begin
         phase_r <= {PH_W{1'b0}};
         wave_r  <= 1'b1;
      end else if (enable) begin
         if (phase_r == half - PH_W'(1)) begin
            phase_r <= {PH_W{1'b0}};
            wave_r  <= ~wave_r;
         end else begin
            phase_r <= phase_r + PH_W'(1);
         end
      end else begin
         phase_r <= {PH_W{1'b0}};
         wave_r  <= 1'b0;
      end
   end

   assign wave = wave_r;

endmodule

// File: rtl/buzzer_pattern_gen.sv
// Event-driven buzzer sequencer: turns one-cycle game events into timed
// tone patterns, with higher-priority events pre-empting the current one.
module buzzer_pattern_gen
   import buzzer_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int UNIT_MS    = 100,
   parameter int TONE_HI_HZ = 2000,
   parameter int TONE_LO_HZ = 1000
) (
   input  logic clk,
   input  logic RST,
   input  logic evt_key,
   input  logic evt_ok,
   input  logic evt_fail,
   output logic buzzer,
   output logic busy
);

   localparam int UNIT_CYC = CLK_HZ / 1000 * UNIT_MS;
   localparam int HALF_HI  = CLK_HZ / (2 * TONE_HI_HZ);
   localparam int HALF_LO  = CLK_HZ / (2 * TONE_LO_HZ);
   localparam int DUR_W    = $clog2(UNIT_CYC * 5 + 1);
   // Sized for the longer half-period so either tone fits
   localparam int HALF_MAX = (HALF_HI > HALF_LO) ? HALF_HI : HALF_LO;
   localparam int PH_W     = $clog2(HALF_MAX + 1);

   if (UNIT_CYC < 1) begin : g_bad_unit
      $error("buzzer_pattern_gen: UNIT_CYC must be >= 1");
   end
   if (HALF_HI < 1) begin : g_bad_half_hi
      $error("buzzer_pattern_gen: HALF_HI must be >= 1");
   end
   if (HALF_LO < 1) begin : g_bad_half_lo
      $error("buzzer_pattern_gen: HALF_LO must be >= 1");
   end

   // Last-cycle index of a segment lasting 'units' pattern units
   function automatic logic [DUR_W-1:0] seg_last(input logic [UNITS_W-1:0] units);
      return DUR_W'(units) * DUR_W'(UNIT_CYC) - DUR_W'(1);
   endfunction

   state_t              state_r;
   pat_t                pat_r;
   logic [UNITS_W-1:0]  beeps_left_r;
   logic [DUR_W-1:0]    dur_r;
   logic                busy_r;

   pat_t                req_s;
   pat_t                cur_pri_s;
   logic                seg_end_s;
   logic                ending_s;
   logic                accept_s;
   logic                restart_s;
   logic                enable_s;
   logic [PH_W-1:0]     half_s;
   logic                wave_s;

   // Event arbitration and divider control derived from the current segment
   always_comb begin
      req_s     = pat_of_events(evt_fail, evt_ok, evt_key);
      seg_end_s = (dur_r == {DUR_W{1'b0}});
      ending_s  = 1'b0;
      cur_pri_s = pat_r;
      if (state_r == ST_IDLE) begin
         ending_s = 1'b1;
      end else if ((state_r == ST_TONE) && seg_end_s && (beeps_left_r == 3'd0)) begin
         // Final cycle of the pattern: any event may follow without a dead cycle
         ending_s = 1'b1;
      end else begin
         ending_s = 1'b0;
      end
      if (ending_s) begin
         cur_pri_s = PAT_NONE;
      end else begin
         cur_pri_s = pat_r;
      end
      accept_s  = (req_s > cur_pri_s);
      restart_s = accept_s || ((state_r == ST_GAP) && seg_end_s);
      enable_s  = (state_r == ST_TONE) && !seg_end_s;
      if (pat_tone_lo(pat_r)) begin
         half_s = PH_W'(HALF_LO);
      end else begin
         half_s = PH_W'(HALF_HI);
      end
   end

   // Sequencer FSM: segment timing, beep bookkeeping and registered busy
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_r      <= ST_IDLE;
         pat_r        <= PAT_NONE;
         beeps_left_r <= 3'd0;
         dur_r        <= {DUR_W{1'b0}};
         busy_r       <= 1'b0;
      end else if (accept_s) begin
         state_r      <= ST_TONE;
         pat_r        <= req_s;
         beeps_left_r <= pat_beeps(req_s) - 3'd1;
         dur_r        <= seg_last(pat_tone_units(req_s));
         busy_r       <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               busy_r <= 1'b0;
            end
            ST_TONE: begin
               if (seg_end_s) begin
                  if (beeps_left_r != 3'd0) begin
                     state_r <= ST_GAP;
                     dur_r   <= seg_last(pat_gap_units(pat_r));
                     busy_r  <= 1'b1;
                  end else begin
                     state_r <= ST_IDLE;
                     pat_r   <= PAT_NONE;
                     dur_r   <= {DUR_W{1'b0}};
                     busy_r  <= 1'b0;
                  end
               end else begin
                  dur_r <= dur_r - DUR_W'(1);
               end
            end
            ST_GAP: begin
               if (seg_end_s) begin
                  state_r      <= ST_TONE;
                  beeps_left_r <= beeps_left_r - 3'd1;
                  dur_r        <= seg_last(pat_tone_units(pat_r));
                  busy_r       <= 1'b1;
               end else begin
                  dur_r <= dur_r - DUR_W'(1);
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               pat_r        <= PAT_NONE;
               beeps_left_r <= 3'd0;
               dur_r        <= {DUR_W{1'b0}};
               busy_r       <= 1'b0;
            end
         endcase
      end
   end

   tone_divider #(
      .PH_W(PH_W)
   ) u_tone (
      .clk     (clk),
      .rst     (RST),
      .enable  (enable_s),
      .restart (restart_s),
      .half    (half_s),
      .wave    (wave_s)
   );

   assign buzzer = wave_s;
   assign busy   = busy_r;

endmodule

// File: tb/tb_buzzer_pattern_gen.sv
// Scoreboard bench for buzzer_pattern_gen: a pattern-level reference model
// queues the expected per-cycle {busy,buzzer}; a monitor pops and compares.
module tb_buzzer_pattern_gen;

   localparam int UNIT  = 20;   // 20000 Hz / 1000 * 1 ms
   localparam int HHALF = 5;    // 20000 / (2*2000)
   localparam int LHALF = 10;   // 20000 / (2*1000)

   logic clk = 1'b0;
   logic RST = 1'b1;
   logic evt_key = 1'b0;
   logic evt_ok = 1'b0;
   logic evt_fail = 1'b0;
   logic buzzer;
   logic busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [1:0] exp_q[$];   // {busy, buzzer} for upcoming cycles
   int cur_pat = 0;        // 0 none, 1 key, 2 ok, 3 fail
   int req;
   int cur;

   buzzer_pattern_gen #(
      .CLK_HZ(20000), .UNIT_MS(1), .TONE_HI_HZ(2000), .TONE_LO_HZ(1000)
   ) dut (
      .clk(clk), .RST(RST), .evt_key(evt_key), .evt_ok(evt_ok),
      .evt_fail(evt_fail), .buzzer(buzzer), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic void push_tone(int len, int half);
      for (int k = 0; k < len; k++) begin
         exp_q.push_back({1'b1, (((k / half) % 2) == 0) ? 1'b1 : 1'b0});
      end
   endfunction

   function automatic void push_gap(int len);
      for (int k = 0; k < len; k++) begin
         exp_q.push_back(2'b10);
      end
   endfunction

   function automatic void load_pattern(int p);
      exp_q.delete();
      case (p)
         1: push_tone(UNIT, HHALF);
         2: begin
            push_tone(UNIT, HHALF); push_gap(UNIT);
            push_tone(UNIT, HHALF); push_gap(UNIT);
            push_tone(UNIT, HHALF);
         end
         3: push_tone(5 * UNIT, LHALF);
         default: ;
      endcase
   endfunction

   // Reference model: arbitration at each sampling edge
   initial begin
      forever begin
         @(posedge clk or posedge RST);
         if (RST) begin
            exp_q.delete();
            cur_pat = 0;
         end else begin
            req = evt_fail ? 3 : (evt_ok ? 2 : (evt_key ? 1 : 0));
            cur = (exp_q.size() == 0) ? 0 : cur_pat;
            if (req > cur) begin
               cur_pat = req;
               load_pattern(req);
            end
         end
      end
   end

   // Monitor: one comparison per cycle, sampled on the falling edge
   initial begin
      logic [1:0] exp;
      forever begin
         @(negedge clk);
         cyc++;
         if (RST) begin
            exp = 2'b00;
         end else if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
         end else begin
            exp = 2'b00;
         end
         checks++;
         if ({busy, buzzer} !== exp) begin
            failures++;
            $display("FAIL scoreboard cycle=%0d busy,buzzer actual=%b%b expected=%b",
                     cyc, busy, buzzer, exp);
         end
      end
   end

   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   // bits = {fail, ok, key}
   task automatic pulse(logic [2:0] bits);
      @(negedge clk);
      {evt_fail, evt_ok, evt_key} = bits;
      @(negedge clk);
      {evt_fail, evt_ok, evt_key} = 3'b000;
   endtask

   initial begin
      idle(3);
      RST = 1'b0;
      idle(200);                 // idle after reset
      pulse(3'b001); idle(40);   // KEY
      pulse(3'b010); idle(110);  // OK
      pulse(3'b100); idle(110);  // FAIL
      pulse(3'b101); idle(110);  // KEY+FAIL together
      pulse(3'b001); idle(3); pulse(3'b010); idle(110);   // OK pre-empts KEY
      pulse(3'b010); idle(30); pulse(3'b001); idle(110);  // KEY during OK ignored
      pulse(3'b001); idle(5); pulse(3'b001); idle(30);    // KEY during KEY ignored
      pulse(3'b010); idle(25); pulse(3'b100); idle(110);  // FAIL pre-empts OK gap
      pulse(3'b001); idle(18); pulse(3'b001); idle(50);   // back-to-back KEY
      pulse(3'b010); idle(98); pulse(3'b100); idle(110);  // FAIL near OK end

      // Asynchronous reset in the middle of FAIL
      pulse(3'b100); idle(30);
      @(posedge clk);
      #2 RST = 1'b1;
      #1;
      checks++;
      if ({busy, buzzer} !== 2'b00) begin
         failures++;
         $display("FAIL async_reset busy,buzzer actual=%b%b expected=00", busy, buzzer);
      end
      idle(2);
      RST = 1'b0;
      idle(20);

      // Randomized event traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 99) < 3) begin
            {evt_fail, evt_ok, evt_key} = 3'($urandom_range(1, 7));
         end else begin
            {evt_fail, evt_ok, evt_key} = 3'b000;
         end
      end
      @(negedge clk);
      {evt_fail, evt_ok, evt_key} = 3'b000;
      idle(120);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
